// File: rtl/kypd_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : kypd_scan
//  Purpose  : 4x4 matrix keypad scanner. Walks an active-low column drive,
//             samples synchronized row returns, debounces whole-scan frames
//             and emits a debounced key vector plus a one-cycle press event.
//  Revision : 1.0 - initial release
// ============================================================================
module kypd_scan #(
    parameter int SETTLE_CYCLES  = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] key_down,
    output logic        any_key,
    output logic [3:0]  key_code,
    output logic        key_valid
);

    localparam int c_CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int c_STB_W = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_STB_W-1:0] c_STB_MAX     = c_STB_W'(DEBOUNCE_SCANS);

    // Hex value of the key at (row r, column c) on the Pmod KYPD
    function automatic logic [3:0] key_hex(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] v;
        case ({r, c})
            4'b00_00: v = 4'h1;
            4'b00_01: v = 4'h2;
            4'b00_10: v = 4'h3;
            4'b00_11: v = 4'hA;
            4'b01_00: v = 4'h4;
            4'b01_01: v = 4'h5;
            4'b01_10: v = 4'h6;
            4'b01_11: v = 4'hB;
            4'b10_00: v = 4'h7;
            4'b10_01: v = 4'h8;
            4'b10_10: v = 4'h9;
            4'b10_11: v = 4'hC;
            4'b11_00: v = 4'h0;
            4'b11_01: v = 4'hF;
            4'b11_10: v = 4'hE;
            default:  v = 4'hD;
        endcase
        return v;
    endfunction

    // Index of the lowest set bit; only meaningful for a non-zero vector
    function automatic logic [3:0] lowest_bit(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    logic [3:0]          r_row_meta;
    logic [3:0]          r_row_sync;
    logic [1:0]          r_col_idx;
    logic [c_CNT_W-1:0]  r_settle;
    logic [15:0]         r_frame;
    logic [15:0]         r_prev_frame;
    logic [c_STB_W-1:0]  r_stable;

    logic                w_sample;
    logic                w_end_frame;
    logic [15:0]         w_col_bits;
    logic [15:0]         w_frame_done;
    logic [c_STB_W-1:0]  w_stable_next;
    logic [15:0]         w_new_keys;

    // Two-flop synchronizer on the asynchronous row returns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_meta <= 4'b1111;
            r_row_sync <= 4'b1111;
        end else begin
            r_row_meta <= row;
            r_row_sync <= r_row_meta;
        end
    end

    // Exactly one column driven low, selected by the scan index
    always_comb begin
        col = ~(4'b0001 << r_col_idx);
    end

    // Sample decode: keys seen in the current column and the frame including them
    always_comb begin
        w_sample    = (r_settle == c_SETTLE_LAST);
        w_end_frame = w_sample && (r_col_idx == 2'd3);
        w_col_bits  = 16'h0000;
        for (int r = 0; r < 4; r++) begin
            if (!r_row_sync[r]) w_col_bits[key_hex(2'(r), r_col_idx)] = 1'b1;
        end
        w_frame_done = r_frame | w_col_bits;
    end

    // Debounce arithmetic: saturating run length of identical frames
    always_comb begin
        if (w_frame_done == r_prev_frame) begin
            w_stable_next = (r_stable == c_STB_MAX) ? r_stable : r_stable + 1'b1;
        end else begin
            w_stable_next = '0;
        end
        w_new_keys = w_frame_done & ~key_down;
    end

    // Column walk: settle counter, column index and frame accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle  <= '0;
            r_col_idx <= 2'd0;
            r_frame   <= 16'h0000;
        end else if (w_sample) begin
            r_settle  <= '0;
            r_col_idx <= r_col_idx + 2'd1;
            // Clearing at the last sample leaves an empty frame for column 0
            r_frame   <= w_end_frame ? 16'h0000 : w_frame_done;
        end else begin
            r_settle  <= r_settle + 1'b1;
        end
    end

    // Frame-to-frame comparison at the end of every full scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_frame <= 16'h0000;
            r_stable     <= '0;
        end else if (w_end_frame) begin
            r_prev_frame <= w_frame_done;
            r_stable     <= w_stable_next;
        end
    end

    // Debounced state and press event, all updated on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_down  <= 16'h0000;
            any_key   <= 1'b0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (w_end_frame && (w_stable_next == c_STB_MAX)) begin
                key_down <= w_frame_done;
                any_key  <= |w_frame_done;
                if (w_new_keys != 16'h0000) begin
                    key_valid <= 1'b1;
                    key_code  <= lowest_bit(w_new_keys);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kypd_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_kypd_scan
//  Purpose  : Self-checking bench for kypd_scan with a keypad matrix model
//             and a frame-history reference model of the debouncer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_kypd_scan;

    localparam int SETTLE = 4;
    localparam int DEB    = 2;
    localparam int FRAME  = 4 * SETTLE;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] key_down;
    logic        any_key;
    logic [3:0]  key_code;
    logic        key_valid;

    logic [15:0] held;
    int          checks;
    int          failures;
    int          pulses;

    // Reference model state
    logic [15:0] hist[$];
    logic [15:0] exp_kd;
    logic [3:0]  exp_code;
    logic        exp_valid;

    int kmap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};

    kypd_scan #(
        .SETTLE_CYCLES (SETTLE),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row      (row),
        .col      (col),
        .key_down (key_down),
        .any_key  (any_key),
        .key_code (key_code),
        .key_valid(key_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a row is pulled low when its key in the driven column is held
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col[c] && held[kmap[r][c]]) row[r] = 1'b0;
            end
        end
    end

    function automatic logic [3:0] lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return 4'(i);
        end
        return 4'h0;
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(16'h0000);
        exp_kd    = 16'h0000;
        exp_code  = 4'h0;
        exp_valid = 1'b0;
    endtask

    // A frame is accepted once DEB+1 consecutive frames (including the one
    // before the run) are identical; a press event reports the lowest new key.
    task automatic model_frame(input logic [15:0] f);
        logic        all_eq;
        logic [15:0] n;
        hist.push_back(f);
        if (hist.size() > DEB + 1) void'(hist.pop_front());
        all_eq = (hist.size() == DEB + 1);
        foreach (hist[k]) if (hist[k] != f) all_eq = 1'b0;
        exp_valid = 1'b0;
        if (all_eq) begin
            n = f & ~exp_kd;
            if (n != 16'h0000) begin
                exp_valid = 1'b1;
                exp_code  = lowest(n);
            end
            exp_kd = f;
        end
    endtask

    // One full scan frame with the given keys held; checks every cycle
    task automatic run_frame(input logic [15:0] f);
        logic [15:0] old_kd;
        logic [3:0]  old_code;
        logic [1:0]  ci;
        logic [3:0]  exp_col;
        old_kd   = exp_kd;
        old_code = exp_code;
        held     = f;
        model_frame(f);
        for (int i = 0; i < FRAME; i++) begin
            @(posedge clk); #1;
            ci      = 2'(((i + 1) / SETTLE) % 4);
            exp_col = ~(4'b0001 << ci);
            if (key_valid) pulses++;
            checks++;
            if (col !== exp_col) begin
                failures++;
                $display("FAIL col_walk cycle=%0d got=%b exp=%b", i, col, exp_col);
            end
            if (i < FRAME - 1) begin
                checks++;
                if (key_valid !== 1'b0 || key_down !== old_kd || key_code !== old_code) begin
                    failures++;
                    $display("FAIL mid_frame cycle=%0d got valid=%b kd=%h code=%h exp valid=0 kd=%h code=%h",
                             i, key_valid, key_down, key_code, old_kd, old_code);
                end
            end else begin
                checks++;
                if (key_down !== exp_kd || any_key !== (exp_kd != 16'h0000) ||
                    key_valid !== exp_valid || key_code !== exp_code) begin
                    failures++;
                    $display("FAIL frame_end got kd=%h any=%b valid=%b code=%h exp kd=%h any=%b valid=%b code=%h",
                             key_down, any_key, key_valid, key_code,
                             exp_kd, (exp_kd != 16'h0000), exp_valid, exp_code);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        held  = 16'h0000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (col !== 4'b1110 || key_down !== 16'h0 || any_key !== 1'b0 ||
            key_code !== 4'h0 || key_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got col=%b kd=%h any=%b code=%h valid=%b exp col=1110 kd=0 any=0 code=0 valid=0",
                     col, key_down, any_key, key_code, key_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) run_frame(16'h0000);
    endtask

    task automatic test_single_press();
        pulses = 0;
        repeat (5) run_frame(16'h0020);
        checks++;
        if (pulses != 1 || key_down !== 16'h0020 || any_key !== 1'b1 || key_code !== 4'h5) begin
            failures++;
            $display("FAIL single_press got pulses=%0d kd=%h any=%b code=%h exp pulses=1 kd=0020 any=1 code=5",
                     pulses, key_down, any_key, key_code);
        end
    endtask

    task automatic test_release();
        pulses = 0;
        repeat (3) run_frame(16'h0000);
        checks++;
        if (pulses != 0 || key_down !== 16'h0000 || any_key !== 1'b0) begin
            failures++;
            $display("FAIL release got pulses=%0d kd=%h any=%b exp pulses=0 kd=0000 any=0",
                     pulses, key_down, any_key);
        end
    endtask

    task automatic test_bounce();
        pulses = 0;
        for (int t = 0; t < 4; t++) run_frame((t % 2 == 0) ? 16'h0001 : 16'h0000);
        checks++;
        if (pulses != 0 || key_down !== 16'h0000) begin
            failures++;
            $display("FAIL bounce_hold got pulses=%0d kd=%h exp pulses=0 kd=0000", pulses, key_down);
        end
        repeat (3) run_frame(16'h0001);
        checks++;
        if (pulses != 1 || key_down !== 16'h0001 || key_code !== 4'h0) begin
            failures++;
            $display("FAIL bounce_settle got pulses=%0d kd=%h code=%h exp pulses=1 kd=0001 code=0",
                     pulses, key_down, key_code);
        end
        repeat (3) run_frame(16'h0000);
    endtask

    task automatic test_simultaneous();
        pulses = 0;
        repeat (4) run_frame(16'h0408);
        checks++;
        if (pulses != 1 || key_down !== 16'h0408 || key_code !== 4'h3) begin
            failures++;
            $display("FAIL simultaneous got pulses=%0d kd=%h code=%h exp pulses=1 kd=0408 code=3",
                     pulses, key_down, key_code);
        end
    endtask

    task automatic test_added_key();
        repeat (3) run_frame(16'h0008);
        pulses = 0;
        repeat (4) run_frame(16'h2008);
        checks++;
        if (pulses != 1 || key_down !== 16'h2008 || key_code !== 4'hD) begin
            failures++;
            $display("FAIL added_key got pulses=%0d kd=%h code=%h exp pulses=1 kd=2008 code=d",
                     pulses, key_down, key_code);
        end
    endtask

    task automatic test_random();
        logic [15:0] f;
        for (int s = 0; s < 15; s++) begin
            f = 16'($urandom & $urandom);
            repeat ($urandom_range(1, 4)) run_frame(f);
        end
    endtask

    task automatic test_async_reset();
        repeat (3) run_frame(16'h0020);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (col !== 4'b1110 || key_down !== 16'h0 || any_key !== 1'b0 ||
            key_code !== 4'h0 || key_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got col=%b kd=%h any=%b code=%h valid=%b exp col=1110 kd=0 any=0 code=0 valid=0",
                     col, key_down, any_key, key_code, key_valid);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (col !== 4'b1110 || key_valid !== 1'b0 || key_down !== 16'h0) begin
                failures++;
                $display("FAIL reset_hold got col=%b valid=%b kd=%h exp col=1110 valid=0 kd=0",
                         col, key_valid, key_down);
            end
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (4) run_frame(16'h0020);
        checks++;
        if (pulses != 1 || key_code !== 4'h5) begin
            failures++;
            $display("FAIL after_reset got pulses=%0d code=%h exp pulses=1 code=5", pulses, key_code);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        pulses   = 0;
        test_reset();
        test_single_press();
        test_release();
        test_bounce();
        test_simultaneous();
        test_added_key();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
